// File: rtl/store_sequence_checker.sv
// Monitors MIPS data-memory stores against a programmable table of expected stores.
// Optional watchdog on idle RUN cycles is built when STORE_CHECK_TIMEOUT_EN is defined.
module store_sequence_checker #(
  parameter int NUM_CHECKS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        memwrite,
  input  logic [ADDR_W-1:0]                 dataadr,
  input  logic [DATA_W-1:0]                 writedata,
  input  logic                              exp_we,
  input  logic [$clog2(NUM_CHECKS)-1:0]     exp_idx,
  input  logic [ADDR_W-1:0]                 exp_addr,
  input  logic [DATA_W-1:0]                 exp_data,
  input  logic [1:0]                        exp_size,
  input  logic [$clog2(NUM_CHECKS+1)-1:0]   check_count,
  input  logic                              start,
  output logic                              busy,
  output logic                              pass,
  output logic                              fail,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   match_count,
  output logic [$clog2(NUM_CHECKS)-1:0]     fail_idx,
  output logic [2:0]                        fail_code
);

  // state | meaning
  // IDLE  | disarmed, table writable
  // RUN   | comparing each store against entry[ptr]
  // PASS  | all expected stores matched; any further store is a failure
  // FAIL  | first mismatch recorded in fail_idx / fail_code
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  localparam int IDX_W = $clog2(NUM_CHECKS);
  localparam int CNT_W = $clog2(NUM_CHECKS+1);

  localparam logic [2:0] CODE_NONE  = 3'b000;
  localparam logic [2:0] CODE_ADDR  = 3'b001;
  localparam logic [2:0] CODE_SIZE  = 3'b010;
  localparam logic [2:0] CODE_DATA  = 3'b011;
  localparam logic [2:0] CODE_EXTRA = 3'b101;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] tbl_addr [NUM_CHECKS];
  logic [DATA_W-1:0] tbl_data [NUM_CHECKS];
  logic [1:0]        tbl_size [NUM_CHECKS];

  logic [CNT_W-1:0]  count_lat, count_nxt;
  logic [CNT_W-1:0]  match_nxt, match_inc;
  logic              pass_nxt, fail_nxt, busy_nxt;
  logic [IDX_W-1:0]  fidx_nxt, ptr, last_idx;
  logic [2:0]        code_nxt, check_code;
  logic [DATA_W-1:0] data_mask;
  logic              store_seen;

`ifdef STORE_CHECK_TIMEOUT_EN
  localparam int     WD_W = $clog2(TIMEOUT+1);
  localparam logic [2:0] CODE_TIMEOUT = 3'b100;
  logic [WD_W-1:0]   wd, wd_nxt;
  logic              wd_expire;
  assign wd_expire = (wd == WD_W'(TIMEOUT-1));
`endif

  // The pointer always equals the number of matches made so far.
  assign ptr        = match_count[IDX_W-1:0];
  assign match_inc  = match_count + CNT_W'(1);
  assign last_idx   = (count_lat == '0) ? '0 : IDX_W'(count_lat - CNT_W'(1));
  assign store_seen = (memwrite != 2'b00);

  always_comb begin
    data_mask = '1;
    case (memwrite)
      2'b01:   data_mask = DATA_W'(8'hFF);
      2'b10:   data_mask = DATA_W'(16'hFFFF);
      default: data_mask = '1;
    endcase
  end

  always_comb begin
    check_code = CODE_NONE;
    if (dataadr != tbl_addr[ptr])
      check_code = CODE_ADDR;
    else if (memwrite != tbl_size[ptr])
      check_code = CODE_SIZE;
    else if (((writedata ^ tbl_data[ptr]) & data_mask) != '0)
      check_code = CODE_DATA;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_lat;
    match_nxt = match_count;
    pass_nxt  = pass;
    fail_nxt  = fail;
    fidx_nxt  = fail_idx;
    code_nxt  = fail_code;
`ifdef STORE_CHECK_TIMEOUT_EN
    wd_nxt    = wd;
`endif
    case (state)
      RUN: begin
        if (count_lat == '0) begin
          state_nxt = PASS;
          pass_nxt  = 1'b1;
        end else if (store_seen) begin
          if (check_code != CODE_NONE) begin
            state_nxt = FAIL;
            fail_nxt  = 1'b1;
            fidx_nxt  = ptr;
            code_nxt  = check_code;
          end else begin
            match_nxt = match_inc;
`ifdef STORE_CHECK_TIMEOUT_EN
            wd_nxt    = '0;
`endif
            if (match_inc == count_lat) begin
              state_nxt = PASS;
              pass_nxt  = 1'b1;
            end
          end
        end
`ifdef STORE_CHECK_TIMEOUT_EN
        else if (wd_expire) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
          fidx_nxt  = ptr;
          code_nxt  = CODE_TIMEOUT;
        end else begin
          wd_nxt = wd + WD_W'(1);
        end
`endif
      end
      PASS: begin
        if (store_seen) begin
          state_nxt = FAIL;
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b1;
          fidx_nxt  = last_idx;
          code_nxt  = CODE_EXTRA;
        end
      end
      default: ;
    endcase
    // Re-arming wins over an extra store seen in PASS on the same cycle.
    if (start && (state != RUN)) begin
      state_nxt = RUN;
      count_nxt = check_count;
      match_nxt = '0;
      pass_nxt  = 1'b0;
      fail_nxt  = 1'b0;
      fidx_nxt  = '0;
      code_nxt  = CODE_NONE;
`ifdef STORE_CHECK_TIMEOUT_EN
      wd_nxt    = '0;
`endif
    end
    busy_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count_lat   <= '0;
      match_count <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      busy        <= 1'b0;
      fail_idx    <= '0;
      fail_code   <= CODE_NONE;
`ifdef STORE_CHECK_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      state       <= state_nxt;
      count_lat   <= count_nxt;
      match_count <= match_nxt;
      pass        <= pass_nxt;
      fail        <= fail_nxt;
      busy        <= busy_nxt;
      fail_idx    <= fidx_nxt;
      fail_code   <= code_nxt;
`ifdef STORE_CHECK_TIMEOUT_EN
      wd          <= wd_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
        tbl_size[i] <= '0;
      end
    end else if (exp_we && (state != RUN)) begin
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
      tbl_size[exp_idx] <= exp_size;
    end
  end

endmodule

// File: tb/tb_store_sequence_checker.sv
// Bench for store_sequence_checker: directed cases plus randomized store sequences
// checked against a behavioural model of the expected-store rules.
module tb_store_sequence_checker;

  localparam int N  = 8;
  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memwrite;
  logic [31:0] dataadr, writedata;
  logic        exp_we;
  logic [2:0]  exp_idx;
  logic [31:0] exp_addr, exp_data;
  logic [1:0]  exp_size;
  logic [3:0]  check_count;
  logic        start;
  logic        busy, pass, fail;
  logic [3:0]  match_count;
  logic [2:0]  fail_idx;
  logic [2:0]  fail_code;

  store_sequence_checker #(
    .NUM_CHECKS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_size(exp_size),
    .check_count(check_count), .start(start), .busy(busy), .pass(pass),
    .fail(fail), .match_count(match_count), .fail_idx(fail_idx),
    .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected-store list plus progress through it.
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];
  int          m_size [N];
  bit          m_armed, m_done_ok, m_done_bad;
  bit          m_pass, m_fail;
  int          m_count, m_matched, m_fidx, m_code, m_idle;

  function automatic logic [31:0] keep_low(input logic [31:0] v, input int size);
    if (size == 1) return v % 256;
    if (size == 2) return v % 65536;
    return v;
  endfunction

  task automatic model_edge();
    int e, c;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_addr[i] = 0; m_data[i] = 0; m_size[i] = 0;
      end
      m_armed = 0; m_done_ok = 0; m_done_bad = 0;
      m_pass = 0; m_fail = 0; m_count = 0; m_matched = 0;
      m_fidx = 0; m_code = 0; m_idle = 0;
      return;
    end
    if (m_armed) begin
      if (m_count == 0) begin
        m_armed = 0; m_done_ok = 1; m_pass = 1;
      end else if (memwrite != 0) begin
        e = m_matched;
        c = 0;
        if (dataadr != m_addr[e]) c = 1;
        else if (int'(memwrite) != m_size[e]) c = 2;
        else if (keep_low(writedata, m_size[e]) != keep_low(m_data[e], m_size[e])) c = 3;
        if (c != 0) begin
          m_armed = 0; m_done_bad = 1; m_fail = 1; m_fidx = e; m_code = c;
        end else begin
          m_matched++;
          m_idle = 0;
          if (m_matched == m_count) begin
            m_armed = 0; m_done_ok = 1; m_pass = 1;
          end
        end
      end else begin
`ifdef STORE_CHECK_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          m_armed = 0; m_done_bad = 1; m_fail = 1; m_fidx = m_matched; m_code = 4;
        end
`endif
      end
    end else begin
      if (m_done_ok && memwrite != 0) begin
        m_done_ok = 0; m_done_bad = 1;
        m_pass = 0; m_fail = 1; m_code = 5;
        m_fidx = (m_count == 0) ? 0 : m_count - 1;
      end
      if (exp_we) begin
        m_addr[exp_idx] = exp_addr;
        m_data[exp_idx] = exp_data;
        m_size[exp_idx] = int'(exp_size);
      end
      if (start) begin
        m_armed = 1; m_done_ok = 0; m_done_bad = 0;
        m_count = int'(check_count); m_matched = 0;
        m_pass = 0; m_fail = 0; m_fidx = 0; m_code = 0; m_idle = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("busy",        busy,        m_armed);
    check_eq("pass",        pass,        m_pass);
    check_eq("fail",        fail,        m_fail);
    check_eq("match_count", match_count, m_matched);
    check_eq("fail_idx",    fail_idx,    m_fidx);
    check_eq("fail_code",   fail_code,   m_code);
    memwrite = 2'b00;
    start    = 1'b0;
    exp_we   = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d, input int sz);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_addr = a; exp_data = d; exp_size = 2'(sz);
    tick();
  endtask

  task automatic arm(input int cnt);
    check_count = 4'(cnt); start = 1'b1;
    tick();
  endtask

  task automatic store(input int sz, input logic [31:0] a, input logic [31:0] d);
    memwrite = 2'(sz); dataadr = a; writedata = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load_seq3();
    load(0, 32'd84, 32'h1234_5678, 3);
    load(1, 32'd88, 32'h0000_AAFF, 2);
    load(2, 32'd80, 32'h0000_0055, 1);
  endtask

  initial begin
    int cnt, sz, mode, b;
    logic [31:0] a, d;

    reset = 1'b1; memwrite = 0; dataadr = 0; writedata = 0;
    exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0; exp_size = 0;
    check_count = 0; start = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_code", fail_code, 3'b000);

    // single byte store, upper data bits don't-care
    load(0, 32'd80, 32'h0000_00FF, 1);
    arm(1);
    store(1, 32'd80, 32'hAAAA_AAFF);
    check_eq("byte_pass", pass, 1'b1);
    check_eq("byte_mc",   match_count, 4'd1);

    // three back-to-back stores
    load_seq3();
    arm(3);
    store(3, 32'd84, 32'h1234_5678);
    store(2, 32'd88, 32'hFFFF_AAFF);
    check_eq("seq3_not_yet", pass, 1'b0);
    store(1, 32'd80, 32'h0000_0055);
    check_eq("seq3_pass", pass, 1'b1);

    // one extra store after PASS
    store(3, 32'h0000_0100, 32'h0);
    check_eq("extra_fail", fail, 1'b1);
    check_eq("extra_pass", pass, 1'b0);
    check_eq("extra_code", fail_code, 3'b101);
    check_eq("extra_idx",  fail_idx,  3'd2);
    idle(1);

    // 2nd and 3rd stores swapped
    arm(3);
    store(3, 32'd84, 32'h1234_5678);
    store(1, 32'd80, 32'h0000_0055);
    check_eq("swap_idx",  fail_idx,  3'd1);
    check_eq("swap_code", fail_code, 3'b001);
    store(2, 32'd88, 32'h0000_AAFF);

    // size then data mismatch on an expected halfword
    load(0, 32'd88, 32'h0000_AAFF, 2);
    arm(1);
    store(3, 32'd88, 32'h0000_AAFF);
    check_eq("size_code", fail_code, 3'b010);
    check_eq("size_idx",  fail_idx,  3'd0);
    arm(1);
    store(2, 32'd88, 32'h0000_AAFE);
    check_eq("data_code", fail_code, 3'b011);
    check_eq("data_idx",  fail_idx,  3'd0);

    // reset mid-run with one of three matched
    load_seq3();
    arm(3);
    store(3, 32'd84, 32'h1234_5678);
    check_eq("mid_mc", match_count, 4'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_mc",   match_count, 4'd0);

    // table writes during RUN are ignored
    load(0, 32'd80, 32'h0000_0011, 1);
    arm(1);
    load(0, 32'd90, 32'h0000_0022, 1);
    store(1, 32'd80, 32'h0000_0011);
    check_eq("we_run_pass", pass, 1'b1);

    // zero-length run
    arm(0);
    check_eq("cnt0_busy", busy, 1'b1);
    idle(1);
    check_eq("cnt0_pass", pass, 1'b1);

`ifdef STORE_CHECK_TIMEOUT_EN
    load(0, 32'd80, 32'h0000_0001, 1);
    arm(1);
    idle(TO - 1);
    check_eq("to_early", fail, 1'b0);
    idle(1);
    check_eq("to_code", fail_code, 3'b100);
    arm(1);
    idle(TO - 1);
    store(1, 32'd80, 32'h0000_0001);
    check_eq("to_store_pass", pass, 1'b1);
    arm(1);
    idle(TO - 1);
    store(1, 32'd81, 32'h0000_0001);
    check_eq("to_store_code", fail_code, 3'b001);
`endif

    // randomized sequences with occasional corruption
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        load(i, 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom(), $urandom_range(1, 3));
      cnt = $urandom_range(0, N);
      arm(cnt);
      for (int k = 0; k <= cnt; k++) begin
        idle($urandom_range(0, 2));
        a  = m_addr[k % N];
        d  = m_data[k % N];
        sz = m_size[k % N];
        mode = $urandom_range(0, 11);
        if (mode == 0) a = a + 32'd4;
        else if (mode == 1) sz = (sz % 3) + 1;
        else if (mode == 2) begin
          b = $urandom_range(0, (sz == 1) ? 7 : (sz == 2) ? 15 : 31);
          d = d ^ (32'h1 << b);
        end else if (sz == 1) d = ($urandom() & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
        else if (sz == 2) d = ($urandom() & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
        store(sz, a, d);
      end
      idle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_sequence_checker.md
# store_sequence_checker

Synthesizable self-checking monitor for the single-cycle MIPS data-memory write port. It sits beside `top` in simulation or FPGA bring-up and watches `memwrite`/`dataadr`/`writedata`. It compares each store, in order, against a programmable table of expected stores of byte, halfword or word size. It reports pass or fail with the index and cause of the first mismatch.

## Interface
Parameters:
- `NUM_CHECKS`, 8: depth of the expected-store table.
- `ADDR_W`, 32: width of the address compare.
- `DATA_W`, 32: width of the store data.
- `TIMEOUT`, 1000: cycles allowed between arming or the last match and the next store (only with the timeout feature).

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `memwrite`  in  2  store size: 00 none, 01 byte, 10 halfword, 11 word.
- `dataadr`  in  ADDR_W  store address.
- `writedata`  in  DATA_W  store data, right-aligned.
- `exp_we`  in  1  table write strobe.
- `exp_idx`  in  $clog2(NUM_CHECKS)  table write index.
- `exp_addr`  in  ADDR_W  expected address.
- `exp_data`  in  DATA_W  expected data.
- `exp_size`  in  2  expected size, same encoding as `memwrite`.
- `check_count`  in  $clog2(NUM_CHECKS+1)  number of entries to check; latched on `start`.
- `start`  in  1  arm pulse.
- `busy`  out  1  high in RUN.
- `pass`  out  1  sticky success.
- `fail`  out  1  sticky failure.
- `match_count`  out  $clog2(NUM_CHECKS+1)  stores matched so far.
- `fail_idx`  out  $clog2(NUM_CHECKS)  entry index at failure.
- `fail_code`  out  3  cause: 000 none, 001 address, 010 size, 011 data, 100 timeout, 101 extra store.

## Operation
- FSM states are IDLE, RUN, PASS and FAIL.
- Reset: state goes to IDLE. All table entries, counters and outputs clear to 0. Reset taken mid-RUN aborts the run with no pass or fail reported.
- `exp_we` writes the entry at `exp_idx`. It is accepted in IDLE, PASS and FAIL. It is ignored in RUN.
- `start` is accepted in IDLE, PASS and FAIL. It latches `check_count`, clears the pointer, `match_count`, `pass`, `fail`, `fail_idx` and `fail_code`, and enters RUN. `start` in RUN is ignored.
- RUN with a latched count of 0 goes to PASS on the next edge.
- In RUN, each cycle with `memwrite != 00` checks entry[ptr], in priority order:
  - address mismatch gives code 001;
  - `memwrite != exp_size` gives code 010;
  - a data mismatch gives code 011. Data is masked by size: bits [7:0] for a byte, [15:0] for a halfword, full DATA_W for a word. Unmasked upper bits of `writedata` are don't-care.
- Any mismatch: go to FAIL, set `fail_idx` to ptr and set `fail_code`.
- Match: ptr and `match_count` increment. When `match_count` reaches the latched count, go to PASS.
- A store seen in PASS sets `fail`, clears `pass`, sets `fail_code` to 101 and `fail_idx` to the last index, then goes to FAIL. This catches a program that writes past its last expected store.
- Stores in IDLE and FAIL are ignored.
- `pass` and `fail` are never high together.

## Timing
- All outputs are registered. A store sampled at edge N is reflected in outputs after edge N.
- A store in the same cycle as `start` is not checked; checking begins the cycle after RUN is entered.
- `busy` rises the cycle after `start` and falls the cycle after a PASS or FAIL transition.
- With a single-cycle CPU one store arrives per cycle at most. Back-to-back stores are checked on consecutive cycles with no stall.

## Configuration
- `STORE_CHECK_TIMEOUT_EN` defined:
  - A watchdog counter clears on entering RUN and on each match, and increments in RUN on cycles without a store.
  - When it reaches TIMEOUT, the FSM goes to FAIL with code 100 and `fail_idx` set to ptr.
  - A store on the same cycle as expiry is checked normally and takes precedence over the timeout.
- Not defined: no counter is built, and RUN waits indefinitely. Code 100 is never produced.

## Test plan
- Byte store: load entry 0 = {addr 80, data 0x000000FF, size 01}, count 1, start. Then drive `memwrite=01`, `dataadr=80`, `writedata=0xAAAA_AAFF` -> `pass=1`, `match_count=1`, `fail_code=000`.
- Sequence of 3: word at 84 = 0x12345678, half at 88 = 0xAAFF, byte at 80 = 0x55, applied back-to-back -> `pass` one cycle after the third store. Swapping the 2nd and 3rd stores -> `fail`, `fail_idx=1`, `fail_code=001`.
- Size and data: an expected halfword at 88 driven as a word -> code 010. The same halfword driven with data 0xAAFE -> code 011. Both have `fail_idx=0`.
- Extra store: after PASS, one more store to any address -> `fail=1`, `pass=0`, `fail_code=101`.
- Reset in RUN, with 1 of 3 matched -> all outputs 0 and IDLE on the next cycle. Also check `exp_we` during RUN is ignored, and `check_count=0` gives `pass` one cycle after RUN is entered.
- Timeout (macro on, TIMEOUT=10): arm with no stores -> `fail_code=100` exactly 10 cycles after RUN is entered. A store landing on the expiry cycle is checked instead.
